// File: rtl/req_enc_pkg.sv
// ----------------------------------------------------------------------------
// req_enc_pkg
// Shared constants and types for the sequential 8-to-3 request encoder.
//   N_IN            : number of request lines (fixed at 8)
//   IDX_W           : width of a request index (clog2(N_IN))
//   req_enc_state_t : handshake state (IDLE / PRESENT)
//   req_idx_t       : a request index / presented code
//   idx_to_onehot   : expands an index into a one-hot request mask
// ----------------------------------------------------------------------------
package req_enc_pkg;

    localparam int N_IN  = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE,
        PRESENT
    } req_enc_state_t;

    typedef logic [IDX_W-1:0] req_idx_t;

    // Turns a presented code back into the pending bit it refers to, so the
    // acked request can be cleared from the pending register.
    function automatic logic [N_IN-1:0] idx_to_onehot(input req_idx_t idx);
        logic [N_IN-1:0] one;
        one = {{(N_IN-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/req_encoder8to3_prio.sv
// ----------------------------------------------------------------------------
// priority_enc8
// Purely combinational circular priority search over 8 request bits.
// The search begins at index 'start' and walks upward, wrapping 7 -> 0; the
// first set bit found is reported.
//   vec   [7:0] in  : request vector to search
//   start [2:0] in  : first index examined
//   idx   [2:0] out : index of the first set bit at or after start (0 if none)
//   found       out : at least one bit of vec is set
// ----------------------------------------------------------------------------
module priority_enc8
    import req_enc_pkg::*;
(
    input  logic [N_IN-1:0] vec,
    input  req_idx_t        start,
    output req_idx_t        idx,
    output logic            found
);

    req_idx_t cand;

    // Walk the candidates from the farthest offset back to offset 0 so that
    // the closest set bit to 'start' is the last one to be written and wins.
    // The 3-bit addition provides the 7 -> 0 wrap for free.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            cand = start + IDX_W'(k);
            if (vec[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_encoder8to3.sv
// ----------------------------------------------------------------------------
// req_encoder8to3
// Sequential 8-to-3 request encoder. Single-cycle requests are collected into
// a sticky pending register; one pending index at a time is presented as a
// 3-bit code with a valid/ack handshake.
//
// Ports:
//   clk            in  : system clock, all state changes on the rising edge
//   reset          in  : synchronous active-high reset
//   en             in  : request capture enable (req ignored when 0)
//   req      [7:0] in  : request lines, a high bit sets its pending bit
//   code     [2:0] out : index of the presented request, held while valid
//   valid          out : code is meaningful
//   ack            in  : consumer accepts code (ignored while valid=0)
//   pending  [7:0] out : current pending register
//   overflow       out : sticky, a request hit an already-pending bit
//
// Configuration:
//   REQ_ENC_RR_PRIORITY_EN : when defined, selection is round-robin starting
//                            just after the last granted index; when left
//                            undefined, the lowest pending index always wins.
// ----------------------------------------------------------------------------
module req_encoder8to3
    import req_enc_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [N_IN-1:0] req,
    output req_idx_t        code,
    output logic            valid,
    input  logic            ack,
    output logic [N_IN-1:0] pending,
    output logic            overflow
);

    req_enc_state_t  state;
    req_enc_state_t  state_next;
    req_idx_t        code_next;
    req_idx_t        last_grant;
    req_idx_t        last_grant_next;
    req_idx_t        search_start;
    req_idx_t        sel_idx;
    logic            sel_found;
    logic [N_IN-1:0] clr;
    logic [N_IN-1:0] set_bits;
    logic [N_IN-1:0] pending_next;
    logic            overflow_next;

`ifdef REQ_ENC_RR_PRIORITY_EN
    // Round-robin: start one past the last grant. last_grant resets to 7, so
    // the very first search starts at index 0.
    assign search_start = last_grant + 1'b1;
`else
    // Fixed priority: always start at index 0 so the lowest index wins.
    assign search_start = '0;
`endif

    // Selection always looks at the registered pending bits, never raw req,
    // so a request is only offered once it has been captured.
    priority_enc8 u_prio (
        .vec   (pending),
        .start (search_start),
        .idx   (sel_idx),
        .found (sel_found)
    );

    // State register plus the registered datapath. Everything resets
    // together, so a reset mid-transfer drops both the pending requests and
    // the presented code, and the ack of that cycle has no influence.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            code       <= '0;
            pending    <= '0;
            overflow   <= 1'b0;
            last_grant <= IDX_W'(N_IN - 1);
        end else begin
            state      <= state_next;
            code       <= code_next;
            pending    <= pending_next;
            overflow   <= overflow_next;
            last_grant <= last_grant_next;
        end
    end

    // Pending/overflow update. A bit is cleared only by an ack of the code
    // being presented; a new request on that same bit in the same cycle
    // re-arms it (set wins). Hitting a bit that stays pending is an overflow,
    // which includes re-requesting the presented bit without an ack.
    always_comb begin
        clr = '0;
        if (state == PRESENT && ack) begin
            clr = idx_to_onehot(code);
        end
        set_bits      = en ? req : '0;
        pending_next  = (pending & ~clr) | set_bits;
        overflow_next = overflow | (|(set_bits & pending & ~clr));
    end

    // Next-state logic for the two-state handshake. IDLE latches the selected
    // index as soon as anything is pending; PRESENT holds the code until the
    // consumer acks, which forces one IDLE cycle between grants.
    always_comb begin
        state_next      = state;
        code_next       = code;
        last_grant_next = last_grant;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_next = PRESENT;
                    code_next  = sel_idx;
                end
            end
            PRESENT: begin
                if (ack) begin
                    state_next      = IDLE;
                    last_grant_next = code;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode: the code is valid exactly while it is being presented.
    always_comb begin
        valid = (state == PRESENT);
    end

endmodule

// File: tb/tb_req_encoder8to3.sv
// ----------------------------------------------------------------------------
// tb_req_encoder8to3
// Self-checking bench for req_encoder8to3: a table of per-cycle vectors,
// hand-written multi-cycle sequences, and a randomized run compared against
// a behavioural model of the pending set and the handshake.
// ----------------------------------------------------------------------------
module tb_req_encoder8to3;

    logic       clk;
    logic       reset;
    logic       en;
    logic [7:0] req;
    logic [2:0] code;
    logic       valid;
    logic       ack;
    logic [7:0] pending;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    req_encoder8to3 dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .req      (req),
        .code     (code),
        .valid    (valid),
        .ack      (ack),
        .pending  (pending),
        .overflow (overflow)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a set of pending request numbers, whether a grant is
    // being shown, which number it is, the sticky overflow and the last grant.
    bit m_pend [8];
    bit m_valid;
    int m_code;
    bit m_over;
    int m_last;

    // Next grant: scan request numbers starting from the search origin,
    // wrapping modulo 8; -1 when nothing is pending.
    function automatic int modelPick();
        int origin;
`ifdef REQ_ENC_RR_PRIORITY_EN
        origin = (m_last + 1) % 8;
`else
        origin = 0;
`endif
        for (int k = 0; k < 8; k++) begin
            if (m_pend[(origin + k) % 8]) return (origin + k) % 8;
        end
        return -1;
    endfunction

    function automatic logic [7:0] modelPending();
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = m_pend[i];
        return r;
    endfunction

    // Advances the model by one rising edge with the given inputs.
    task automatic modelStep(input bit r, input bit e, input logic [7:0] q, input bit a);
        bit nxt [8];
        bit taken;
        bit newreq;
        int g;
        if (r) begin
            for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
            m_valid = 1'b0;
            m_code  = 0;
            m_over  = 1'b0;
            m_last  = 7;
            return;
        end
        g = m_valid ? -1 : modelPick();
        for (int i = 0; i < 8; i++) begin
            taken  = m_valid && a && (i == m_code);
            newreq = e && q[i];
            if (newreq && m_pend[i] && !taken) m_over = 1'b1;
            nxt[i] = (m_pend[i] && !taken) || newreq;
        end
        if (m_valid && a) begin
            m_last  = m_code;
            m_valid = 1'b0;
        end else if (!m_valid && g >= 0) begin
            m_code  = g;
            m_valid = 1'b1;
        end
        for (int i = 0; i < 8; i++) m_pend[i] = nxt[i];
    endtask

    // Drives one cycle of inputs, lets the rising edge happen, then samples
    // 1 time unit later. The model follows the same inputs.
    task automatic applyStimulus(input bit r, input bit e, input logic [7:0] q, input bit a);
        reset = r;
        en    = e;
        req   = q;
        ack   = a;
        @(posedge clk);
        #1;
        modelStep(r, e, q, a);
    endtask

    // Compares the DUT outputs with expected values. The code is only
    // compared when it is meaningful (valid) or explicitly required (reset).
    task automatic checkOutput(input string name, input bit ev, input int ec,
                               input logic [7:0] ep, input bit eo, input bit cc);
        checks++;
        if (valid !== ev) begin
            errors++;
            $display("[TB] FAIL %s valid got %0b want %0b", name, valid, ev);
        end
        checks++;
        if (pending !== ep) begin
            errors++;
            $display("[TB] FAIL %s pending got %02h want %02h", name, pending, ep);
        end
        checks++;
        if (overflow !== eo) begin
            errors++;
            $display("[TB] FAIL %s overflow got %0b want %0b", name, overflow, eo);
        end
        if (ev || cc) begin
            checks++;
            if (code !== 3'(ec)) begin
                errors++;
                $display("[TB] FAIL %s code got %0d want %0d", name, code, ec);
            end
        end
    endtask

    task automatic step(input string name, input bit r, input bit e, input logic [7:0] q,
                        input bit a, input bit ev, input int ec, input logic [7:0] ep,
                        input bit eo, input bit cc);
        applyStimulus(r, e, q, a);
        checkOutput(name, ev, ec, ep, eo, cc);
    endtask

    typedef struct {
        bit         rst;
        bit         en;
        logic [7:0] req;
        bit         ack;
        bit         ev;
        int         ec;
        logic [7:0] ep;
        bit         eo;
        bit         cc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit r, input bit e, input logic [7:0] q, input bit a,
                                input bit ev, input int ec, input logic [7:0] ep,
                                input bit eo, input bit cc);
        vec_t v;
        v.rst = r;  v.en = e;  v.req = q;  v.ack = a;
        v.ev = ev;  v.ec = ec; v.ep = ep;  v.eo = eo; v.cc = cc;
        return v;
    endfunction

    initial begin
        logic [7:0] exp_p;
        bit         rnd_r;
        bit         rnd_e;
        bit         rnd_a;
        logic [7:0] rnd_q;

        reset = 1'b1;
        en    = 1'b0;
        req   = 8'h00;
        ack   = 1'b0;

        // Single request, held presentation, ack; then the enable gate.
        tbl.push_back(mk(1, 0, 8'h00, 0,  0, 0, 8'h00, 0, 1));
        tbl.push_back(mk(0, 1, 8'h04, 0,  0, 0, 8'h04, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0,  1, 2, 8'h04, 0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 1, 8'h00, 0,  1, 2, 8'h04, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 1,  0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0,  0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 8'h10, 0,  0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 8'h10, 0,  0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 8'h10, 0,  0, 0, 8'h10, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0,  1, 4, 8'h10, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 1,  0, 0, 8'h00, 0, 0));

        $display("[TB] table phase, %0d vectors", tbl.size());
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].rst, tbl[i].en, tbl[i].req, tbl[i].ack);
            checkOutput($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].ec, tbl[i].ep,
                        tbl[i].eo, tbl[i].cc);
        end

        // All eight pending: drained in index order, one grant per 2 cycles.
        $display("[TB] drain phase");
        step("drain_rst", 1, 1, 8'h00, 0, 0, 0, 8'h00, 0, 1);
        step("drain_load", 0, 1, 8'hFF, 0, 0, 0, 8'hFF, 0, 0);
        for (int g = 0; g < 8; g++) begin
            exp_p = 8'hFF << g;
            step($sformatf("drain_show%0d", g), 0, 1, 8'h00, 0, 1, g, exp_p, 0, 0);
            exp_p = 8'hFF << (g + 1);
            step($sformatf("drain_ack%0d", g), 0, 1, 8'h00, 1, 0, 0, exp_p, 0, 0);
        end

        // Priority order after bit 0 is re-armed during its own ack.
        $display("[TB] priority phase");
        step("pri_rst", 1, 1, 8'h00, 0, 0, 0, 8'h00, 0, 1);
        step("pri_load", 0, 1, 8'h81, 0, 0, 0, 8'h81, 0, 0);
        step("pri_g0", 0, 1, 8'h00, 0, 1, 0, 8'h81, 0, 0);
        step("pri_rearm", 0, 1, 8'h01, 1, 0, 0, 8'h81, 0, 0);
`ifdef REQ_ENC_RR_PRIORITY_EN
        step("pri_g1", 0, 1, 8'h00, 0, 1, 7, 8'h81, 0, 0);
        step("pri_a1", 0, 1, 8'h00, 1, 0, 0, 8'h01, 0, 0);
        step("pri_g2", 0, 1, 8'h00, 0, 1, 0, 8'h01, 0, 0);
`else
        step("pri_g1", 0, 1, 8'h00, 0, 1, 0, 8'h81, 0, 0);
        step("pri_a1", 0, 1, 8'h00, 1, 0, 0, 8'h80, 0, 0);
        step("pri_g2", 0, 1, 8'h00, 0, 1, 7, 8'h80, 0, 0);
`endif
        step("pri_a2", 0, 1, 8'h00, 1, 0, 0, 8'h00, 0, 0);

        // Re-arm during ack is not an overflow; re-request while shown is.
        $display("[TB] overflow phase");
        step("ovf_rst", 1, 1, 8'h00, 0, 0, 0, 8'h00, 0, 1);
        step("ovf_load", 0, 1, 8'h08, 0, 0, 0, 8'h08, 0, 0);
        step("ovf_show", 0, 1, 8'h00, 0, 1, 3, 8'h08, 0, 0);
        step("ovf_rearm", 0, 1, 8'h08, 1, 0, 0, 8'h08, 0, 0);
        step("ovf_again", 0, 1, 8'h00, 0, 1, 3, 8'h08, 0, 0);
        step("ovf_hit", 0, 1, 8'h08, 0, 1, 3, 8'h08, 1, 0);
        step("ovf_ack", 0, 1, 8'h00, 1, 0, 0, 8'h00, 1, 0);
        step("ovf_load2", 0, 1, 8'h01, 0, 0, 0, 8'h01, 1, 0);
        step("ovf_show2", 0, 1, 8'h00, 0, 1, 0, 8'h01, 1, 0);
        step("ovf_ack2", 0, 1, 8'h00, 1, 0, 0, 8'h00, 1, 0);

        // Reset while presenting code 5 with overflow set; its ack is ignored.
        $display("[TB] reset phase");
        step("rst_init", 1, 1, 8'h00, 0, 0, 0, 8'h00, 0, 1);
        step("rst_load", 0, 1, 8'h60, 0, 0, 0, 8'h60, 0, 0);
        step("rst_show", 0, 1, 8'h00, 0, 1, 5, 8'h60, 0, 0);
        step("rst_ovf", 0, 1, 8'h60, 0, 1, 5, 8'h60, 1, 0);
        step("rst_mid", 1, 1, 8'h00, 1, 0, 0, 8'h00, 0, 1);
        step("rst_ackidle", 0, 1, 8'h00, 1, 0, 0, 8'h00, 0, 1);

        // Randomized traffic against the model.
        $display("[TB] random phase");
        step("rnd_rst", 1, 1, 8'h00, 0, 0, 0, 8'h00, 0, 1);
        for (int n = 0; n < 600; n++) begin
            rnd_r = ($urandom_range(0, 63) == 0);
            rnd_e = ($urandom_range(0, 3) != 0);
            rnd_a = $urandom_range(0, 1) == 1;
            rnd_q = 8'h00;
            if ($urandom_range(0, 3) == 0)
                rnd_q = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
            applyStimulus(rnd_r, rnd_e, rnd_q, rnd_a);
            checkOutput($sformatf("rnd%0d", n), m_valid, m_code, modelPending(), m_over, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
